// File: rtl/dual_issue_dispatcher.sv
// Dual-issue dispatcher: hazard check against the in-flight register table,
// lane selection between two processors, and one-cycle boot/dispatch pulses.
module dual_issue_dispatcher #(
    parameter int REGISTER_AMOUNT = 32,
    parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
    parameter int INSTR_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [INSTR_WIDTH-1:0]       instr_word,
    input  logic [REG_CTN_WIDTH-1:0]     instr_rs1,
    input  logic [REG_CTN_WIDTH-1:0]     instr_rs2,
    input  logic [REG_CTN_WIDTH-1:0]     instr_rd,
    input  logic [REG_CTN_WIDTH-1:0]     instr_rd2,
    input  logic [REG_CTN_WIDTH-1:0]     instr_rd3,
    input  logic                         instr_three_dest,
    input  logic                         instr_barrier,
    input  logic [0:REGISTER_AMOUNT-1]   processing_register_table,
    input  logic                         synchronized_processors,
    input  logic                         processor_idle_1,
    input  logic                         processor_idle_2,
    output logic                         boot_renew_register_1,
    output logic                         boot_renew_register_2,
    output logic                         boot_renew_3registers_2,
    output logic [REG_CTN_WIDTH*3-1:0]   register_num,
    output logic                         dispatch_valid_1,
    output logic                         dispatch_valid_2,
    output logic [INSTR_WIDTH-1:0]       dispatch_word
);

    typedef enum logic [1:0] {FREE, LAUNCHED, RUNNING} lane_state_t;

    localparam logic [REG_CTN_WIDTH-1:0] LAST_SAFE = REG_CTN_WIDTH'(1);

    lane_state_t                 lane_1, lane_1_nxt, lane_2, lane_2_nxt;
    logic [0:REGISTER_AMOUNT-1]  shadow, hazard_mask, dest_mask;
    logic [REG_CTN_WIDTH*3-1:0]  reg_num_nxt;
    logic avail_1, avail_2, sel_lane_2, sel_avail, barrier_ok;
    logic hz_rs1, hz_rs2, hz_rd, hz_rd2, hz_rd3, hazard;
    logic accept, dispatch, rd_nonzero;

    // Hazard detection, lane selection and handshake.
    always_comb begin
        hazard_mask = processing_register_table | shadow;
        // Registers 0 and 1 are hardwired and never tracked as hazards.
        hz_rs1 = (instr_rs1 > LAST_SAFE) && hazard_mask[instr_rs1];
        hz_rs2 = (instr_rs2 > LAST_SAFE) && hazard_mask[instr_rs2];
        hz_rd  = (instr_rd  > LAST_SAFE) && hazard_mask[instr_rd];
        hz_rd2 = (instr_rd2 > LAST_SAFE) && hazard_mask[instr_rd2];
        hz_rd3 = (instr_rd3 > LAST_SAFE) && hazard_mask[instr_rd3];
        hazard = hz_rs1 | hz_rs2 | hz_rd | (instr_three_dest & (hz_rd2 | hz_rd3));

        avail_1    = (lane_1 == FREE) && processor_idle_1;
        avail_2    = (lane_2 == FREE) && processor_idle_2;
        // Three-destination ops only exist on processor 2; otherwise prefer lane 1.
        sel_lane_2 = instr_three_dest | ~avail_1;
        sel_avail  = sel_lane_2 ? avail_2 : avail_1;

        barrier_ok = (lane_1 == FREE) && (lane_2 == FREE) && processor_idle_1 &&
                     processor_idle_2 && synchronized_processors &&
                     (processing_register_table == '0);

        instr_ready = ~rst & instr_valid &
                      (instr_barrier ? barrier_ok : (~hazard & sel_avail));
        accept      = instr_valid & instr_ready;
        dispatch    = accept & ~instr_barrier;
        rd_nonzero  = (instr_rd != '0);
    end

    // Destination mask for the shadow and the packed register_num value.
    always_comb begin
        dest_mask            = '0;
        dest_mask[instr_rd]  = 1'b1;
        reg_num_nxt          = '0;
        reg_num_nxt[REG_CTN_WIDTH-1:0] = instr_rd;
        if (instr_three_dest) begin
            dest_mask[instr_rd2] = 1'b1;
            dest_mask[instr_rd3] = 1'b1;
            reg_num_nxt[2*REG_CTN_WIDTH-1:REG_CTN_WIDTH]   = instr_rd2;
            reg_num_nxt[3*REG_CTN_WIDTH-1:2*REG_CTN_WIDTH] = instr_rd3;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_1 <= FREE;
            lane_2 <= FREE;
        end else begin
            lane_1 <= lane_1_nxt;
            lane_2 <= lane_2_nxt;
        end
    end

    // Lane next-state: launched on dispatch, running once busy, free once idle again.
    always_comb begin
        lane_1_nxt = lane_1;
        lane_2_nxt = lane_2;
        case (lane_1)
            FREE:     if (dispatch && !sel_lane_2) lane_1_nxt = LAUNCHED;
            LAUNCHED: if (!processor_idle_1)       lane_1_nxt = RUNNING;
            RUNNING:  if (processor_idle_1)        lane_1_nxt = FREE;
            default:                               lane_1_nxt = FREE;
        endcase
        case (lane_2)
            FREE:     if (dispatch && sel_lane_2)  lane_2_nxt = LAUNCHED;
            LAUNCHED: if (!processor_idle_2)       lane_2_nxt = RUNNING;
            RUNNING:  if (processor_idle_2)        lane_2_nxt = FREE;
            default:                               lane_2_nxt = FREE;
        endcase
    end

    // One-cycle dispatch/boot pulses and the shadow covering the table's update lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow                  <= '0;
            dispatch_valid_1        <= 1'b0;
            dispatch_valid_2        <= 1'b0;
            dispatch_word           <= '0;
            register_num            <= '0;
            boot_renew_register_1   <= 1'b0;
            boot_renew_register_2   <= 1'b0;
            boot_renew_3registers_2 <= 1'b0;
        end else begin
            shadow                  <= dispatch ? dest_mask : '0;
            dispatch_valid_1        <= dispatch & ~sel_lane_2;
            dispatch_valid_2        <= dispatch & sel_lane_2;
            dispatch_word           <= dispatch ? instr_word : '0;
            register_num            <= dispatch ? reg_num_nxt : '0;
            boot_renew_register_1   <= dispatch & ~sel_lane_2 & rd_nonzero;
            boot_renew_register_2   <= dispatch & sel_lane_2 & ~instr_three_dest & rd_nonzero;
            boot_renew_3registers_2 <= dispatch & instr_three_dest & rd_nonzero;
        end
    end

endmodule

// File: doc/dual_issue_dispatcher.md
Name: dual_issue_dispatcher

Overview:
- Sits directly upstream of the register-management block, between instruction decode and the two processors.
- Accepts one decoded instruction at a time and checks read-after-write and write-after-write hazards against the in-flight register table.
- Picks a free processor, forwards the instruction to it, and pulses the matching renew-boot strobe with the destination register numbers.
- Also handles barrier instructions, which wait until both processors are synchronized and drained.

Parameters:
- REGISTER_AMOUNT, 32, number of architectural registers.
- REG_CTN_WIDTH, $clog2(REGISTER_AMOUNT), register index width.
- INSTR_WIDTH, 32, forwarded instruction word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  decoded instruction available.
- instr_ready  out  1  instruction accepted this cycle when valid&ready.
- instr_word  in  INSTR_WIDTH  raw instruction forwarded to the chosen processor.
- instr_rs1, instr_rs2  in  REG_CTN_WIDTH each  source registers.
- instr_rd, instr_rd2, instr_rd3  in  REG_CTN_WIDTH each  destinations; rd2/rd3 are used only when instr_three_dest=1.
- instr_three_dest  in  1  three-destination op; issued to processor 2 only.
- instr_barrier  in  1  barrier/sync op.
- processing_register_table  in  [0:REGISTER_AMOUNT-1]  registers currently being renewed.
- synchronized_processors  in  1  both processors synchronized.
- processor_idle_1, processor_idle_2  in  1 each  processor idle flags.
- boot_renew_register_1, boot_renew_register_2  out  1 each  single-destination boot pulses.
- boot_renew_3registers_2  out  1  three-destination boot pulse.
- register_num  out  REG_CTN_WIDTH*3  {rd3,rd2,rd}; rd sits in bits [REG_CTN_WIDTH-1:0].
- dispatch_valid_1, dispatch_valid_2  out  1 each  instruction strobe to each processor.
- dispatch_word  out  INSTR_WIDTH  instruction word for the strobed processor.

Behaviour:
- Reset: all outputs 0, both lanes FREE, shadow mask cleared. rst asserted mid-dispatch aborts everything; no pulse is emitted in that cycle.
- Per-lane FSM, lanes 1 and 2:
  - FREE -> LAUNCHED on dispatch to that lane.
  - LAUNCHED -> RUNNING when the lane's processor_idle_n=0.
  - RUNNING -> FREE when processor_idle_n=1.
  - A lane is available only in FREE with processor_idle_n=1.
- Hazard mask H = processing_register_table OR shadow.
  - shadow holds the destinations dispatched in the previous cycle, because the table updates one cycle after the boot pulse. It is cleared the next cycle.
  - Register indices 0 and 1 are never hazards.
- Hazard when H[rs1], H[rs2] or H[rd] is set. For three-destination ops, H[rd2] and H[rd3] are also checked.
- Lane selection:
  - Three-destination op: lane 2 only.
  - Otherwise lane 1 if available, else lane 2.
  - If both lanes are available, lane 1 is chosen.
- instr_ready is combinational and equals valid & no hazard & the selected lane is available. Barrier ops instead require both lanes FREE, both idles 1, synchronized_processors=1, and the table all zero.
- On accept (registered, 1-cycle latency): the next cycle produces exactly one of the following pulses, each lasting one cycle.
  - dispatch_valid_n with dispatch_word.
  - register_num = {rd3,rd2,rd}, or {0,0,rd} for single-destination ops.
  - The matching boot strobe: boot_renew_register_1, boot_renew_register_2 or boot_renew_3registers_2.
- rd=0: dispatch_valid still fires, but no boot strobe.
- Barrier accept: no dispatch and no boot strobe; it only consumes the instruction.
- At most one accept per cycle. Back-to-back accepts are allowed when both lanes are free and there is no hazard, including the shadow.
- Boot strobes for lane 1 and lane 2 are never asserted in the same cycle.

Test Plan:
- Reset: hold rst high for 3 cycles, valid=1 -> all outputs 0, instr_ready=0 while rst=1; after release, first accept occurs no earlier than cycle 1.
- Single op, rd=5, rs1=2, rs2=3, empty table, both idle -> accept at cycle 0; cycle 1 has boot_renew_register_1=1, register_num[4:0]=5, dispatch_valid_1=1.
- Back-to-back: op A rd=5 to lane 1, next op B rs1=5 -> B stalls via shadow in cycle 1 and until table[5] clears. Independent op C rd=7 instead -> goes to lane 2 the next cycle.
- Three-destination op rd=4,5,6 with lane 1 free and lane 2 busy -> stall. When lane 2 returns FREE -> boot_renew_3registers_2=1, register_num={6,5,4}.
- Barrier with table[9]=1 -> ready=0. After table clears and synchronized_processors=1 -> accepted, with no strobes.
- Assert rst while a lane is LAUNCHED -> lane returns FREE and outputs drop to 0 asynchronously.
